// File: rtl/fb_capture_sequencer.sv
// Frame buffer sequencer: captures one camera frame into the buffer, then maps
// the LCD raster onto buffer read addresses until a refresh re-arms capture.
module fb_capture_sequencer #(
  parameter int unsigned IMG_W          = 640,
  parameter int unsigned IMG_H          = 294,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned REFRESH_CYCLES = 3000000,
  parameter int unsigned ROW_OFFSET     = 145,
  parameter int unsigned COL_OFFSET     = 380
) (
  input  logic              PixelClk,
  input  logic              temp_reset,
  input  logic              cam_vsync,
  input  logic              cam_hsync,
  input  logic              capture_req,
  input  logic [9:0]        disp_line,
  input  logic [10:0]       disp_pixel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_valid,
  output logic              short_frame,
  output logic [1:0]        state_o
);

  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
  localparam int unsigned PTR_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        refresh_q, refresh_d;
  logic [ADDR_W-1:0]  wr_addr_d, rd_addr_d;
  logic               wr_en_d, frame_valid_d, short_frame_d;
  logic               vsync_fall, vsync_rise, last_pix, frame_done;
  logic [31:0]        row_wrap, col_wrap;

  // Exact modulo by a constant: restoring subtract-compare over shifted divisors.
  function automatic logic [31:0] wrap_mod(input logic [31:0] v, input logic [31:0] m);
    logic [63:0] rem;
    logic [63:0] sub;
    rem = {32'd0, v};
    for (int k = 31; k >= 0; k--) begin
      sub = {32'd0, m} << k;
      if (rem >= sub) rem = rem - sub;
    end
    return rem[31:0];
  endfunction

  assign vsync_fall = vsync_q & ~cam_vsync;
  assign vsync_rise = ~vsync_q & cam_vsync;
  assign last_pix   = (wr_ptr_q == PTR_W'(FRAME_PIX - 1));
  assign frame_done = (wr_ptr_q == PTR_W'(FRAME_PIX));
  assign row_wrap   = wrap_mod({22'd0, disp_line} + ROW_OFFSET, IMG_H);
  assign col_wrap   = wrap_mod({21'd0, disp_pixel} + COL_OFFSET, IMG_W);
  assign state_o    = state_q;

  // Write port is a strobe with no backpressure: the buffer takes wr_addr on
  // every cycle wr_en is high; there is no ready and no retry.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    refresh_d     = refresh_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    rd_addr_d     = rd_addr;
    frame_valid_d = frame_valid;
    short_frame_d = 1'b0;
    case (state_q)
      IDLE: state_d = ARM;
      ARM: begin
        if (vsync_fall) begin
          state_d   = CAPTURE;
          wr_ptr_d  = '0;
          wr_addr_d = '0;
        end
      end
      CAPTURE: begin
        // The final pixel (and the cycle after it) outranks an early vsync.
        if (frame_done) begin
          state_d       = SHOW;
          frame_valid_d = 1'b1;
          refresh_d     = '0;
        end else if (cam_hsync && (last_pix || !vsync_rise)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q[ADDR_W-1:0];
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end else if (vsync_rise) begin
          state_d       = ARM;
          wr_ptr_d      = '0;
          short_frame_d = 1'b1;
        end
      end
      SHOW: begin
        rd_addr_d = ADDR_W'(row_wrap * IMG_W + col_wrap);
        if (capture_req || (refresh_q == REFRESH_CYCLES - 1)) begin
          state_d       = ARM;
          frame_valid_d = 1'b0;
          refresh_d     = '0;
        end else begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PixelClk or posedge temp_reset) begin
    if (temp_reset) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b1;
      wr_ptr_q    <= '0;
      refresh_q   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      frame_valid <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= cam_vsync;
      wr_ptr_q    <= wr_ptr_d;
      refresh_q   <= refresh_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      rd_addr     <= rd_addr_d;
      frame_valid <= frame_valid_d;
      short_frame <= short_frame_d;
    end
  end

endmodule

// File: tb/tb_fb_capture_sequencer.sv
// Self-checking bench for fb_capture_sequencer on a reduced frame size, with a
// plain-arithmetic reference for write order, raster mapping and refresh timing.
module tb_fb_capture_sequencer;

  localparam int W  = 40;
  localparam int H  = 12;
  localparam int N  = W * H;
  localparam int AW = 10;
  localparam int RC = 400;
  localparam int RO = 145;
  localparam int CO = 380;

  logic          PixelClk = 1'b0;
  logic          temp_reset, cam_vsync, cam_hsync, capture_req;
  logic [9:0]    disp_line;
  logic [10:0]   disp_pixel;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_en, frame_valid, short_frame;
  logic [1:0]    state_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_rise_cyc = 0;
  logic [AW-1:0] exp_q[$];

  fb_capture_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .REFRESH_CYCLES(RC),
    .ROW_OFFSET(RO), .COL_OFFSET(CO)
  ) dut (
    .PixelClk(PixelClk), .temp_reset(temp_reset), .cam_vsync(cam_vsync),
    .cam_hsync(cam_hsync), .capture_req(capture_req), .disp_line(disp_line),
    .disp_pixel(disp_pixel), .wr_addr(wr_addr), .wr_en(wr_en), .rd_addr(rd_addr),
    .frame_valid(frame_valid), .short_frame(short_frame), .state_o(state_o)
  );

  // Clock / reset block
  always #5 PixelClk = ~PixelClk;
  always @(posedge PixelClk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge PixelClk);
    #1;
  endtask

  function automatic int ref_rd(input int l, input int p);
    return ((l + RO) % H) * W + ((p + CO) % W);
  endfunction

  task automatic test_reset();
    temp_reset = 1'b1; cam_vsync = 1'b1; cam_hsync = 1'b0; capture_req = 1'b0;
    disp_line = '0; disp_pixel = '0;
    #23;
    n_vec++;
    if ({state_o, wr_en, frame_valid, short_frame, wr_addr, rd_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d we=%0b fv=%0b sf=%0b wa=%0d ra=%0d required all 0",
               state_o, wr_en, frame_valid, short_frame, wr_addr, rd_addr);
    end
    @(posedge PixelClk); #1;
    temp_reset = 1'b0;
    n_vec++;
    if (state_o !== 2'd0) begin n_err++; $display("FAIL idle_after_release: state=%0d required 0", state_o); end
    step();
    n_vec++;
    if (state_o !== 2'd1) begin n_err++; $display("FAIL idle_to_arm: state=%0d required 1", state_o); end
    for (int i = 0; i < 6; i++) begin
      cam_hsync = 1'($urandom_range(0, 1));
      capture_req = 1'($urandom_range(0, 1));
      step();
      n_vec++;
      if (state_o !== 2'd1 || wr_en !== 1'b0) begin
        n_err++; $display("FAIL arm_hold: state=%0d we=%0b required 1/0", state_o, wr_en);
      end
    end
    capture_req = 1'b0; cam_hsync = 1'b0;
  endtask

  // Drives one frame of line bursts (already in CAPTURE), checking each write.
  task automatic run_frame(input bit rise_at_last, input bit random_req);
    bit pat[$];
    int k, n_we;
    bit was_full, exp_we, fv_seen;
    logic [AW-1:0] a;
    for (int l = 0; l < H; l++) begin
      repeat ($urandom_range(1, 4)) pat.push_back(1'b0);
      repeat (W) pat.push_back(1'b1);
    end
    repeat (6) pat.push_back(1'b1);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(AW'(i));
    k = 0; n_we = 0; fv_seen = 0;
    foreach (pat[i]) begin
      was_full = (k == N);
      cam_hsync = pat[i];
      capture_req = random_req && !was_full && ($urandom_range(0, 3) == 0);
      if (rise_at_last && k == N - 1 && pat[i]) cam_vsync = 1'b1;
      step();
      exp_we = pat[i] && !was_full;
      if (wr_en) n_we++;
      n_vec++;
      if (wr_en !== exp_we) begin n_err++; $display("FAIL cap_wr_en: k=%0d got %0b required %0b", k, wr_en, exp_we); end
      if (exp_we) begin
        a = exp_q.pop_front();
        n_vec++;
        if (wr_addr !== a) begin n_err++; $display("FAIL cap_wr_addr: got %0d required %0d", wr_addr, a); end
        k++;
      end
      n_vec++;
      if (state_o !== (was_full ? 2'd3 : 2'd2) || frame_valid !== was_full || short_frame !== 1'b0) begin
        n_err++;
        $display("FAIL cap_state: k=%0d state=%0d fv=%0b sf=%0b required state=%0d fv=%0b sf=0",
                 k, state_o, frame_valid, short_frame, was_full ? 3 : 2, was_full);
      end
      if (was_full && !fv_seen) begin fv_rise_cyc = cyc; fv_seen = 1'b1; end
    end
    capture_req = 1'b0; cam_hsync = 1'b0;
    n_vec++;
    if (n_we !== N) begin n_err++; $display("FAIL cap_write_count: got %0d required %0d", n_we, N); end
  endtask

  task automatic test_capture();
    cam_vsync = 1'b0;
    step();
    n_vec++;
    if (state_o !== 2'd2 || wr_addr !== '0 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL cap_start: state=%0d wa=%0d we=%0b required 2/0/0", state_o, wr_addr, wr_en);
    end
    run_frame(1'b0, 1'b1);
  endtask

  task automatic test_display();
    int l, p;
    for (int i = 0; i < 60; i++) begin
      l = (i == 0) ? 0 : (i == 1) ? 1023 : (i == 2) ? 200 : $urandom_range(0, 1023);
      p = (i == 0) ? 0 : (i == 1) ? 2047 : (i == 2) ? 300 : $urandom_range(0, 2047);
      disp_line = 10'(l); disp_pixel = 11'(p);
      step();
      n_vec++;
      if (rd_addr !== AW'(ref_rd(l, p)) || state_o !== 2'd3) begin
        n_err++; $display("FAIL disp_rd_addr: l=%0d p=%0d got %0d state=%0d required %0d state=3",
                          l, p, rd_addr, state_o, ref_rd(l, p));
      end
      n_vec++;
      if (int'(rd_addr) >= N) begin n_err++; $display("FAIL disp_range: got %0d required < %0d", rd_addr, N); end
    end
  endtask

  task automatic test_refresh_auto();
    int l, p, guard;
    logic [AW-1:0] held;
    l = 0; p = 0; guard = 0;
    while (state_o === 2'd3 && guard < RC + 50) begin
      l = $urandom_range(0, 1023); p = $urandom_range(0, 2047);
      disp_line = 10'(l); disp_pixel = 11'(p);
      step();
      guard++;
    end
    n_vec++;
    if (state_o !== 2'd1 || frame_valid !== 1'b0) begin
      n_err++; $display("FAIL refresh_timeout: state=%0d fv=%0b required ARM/0 within %0d cycles", state_o, frame_valid, RC + 50);
    end
    n_vec++;
    if (cyc - fv_rise_cyc !== RC) begin
      n_err++; $display("FAIL refresh_interval: got %0d cycles required %0d", cyc - fv_rise_cyc, RC);
    end
    n_vec++;
    if (rd_addr !== AW'(ref_rd(l, p))) begin
      n_err++; $display("FAIL refresh_last_rd: got %0d required %0d", rd_addr, ref_rd(l, p));
    end
    held = rd_addr;
    for (int i = 0; i < 4; i++) begin
      disp_line = 10'($urandom_range(0, 1023)); disp_pixel = 11'($urandom_range(0, 2047));
      step();
      n_vec++;
      if (rd_addr !== held) begin n_err++; $display("FAIL rd_hold: got %0d required %0d", rd_addr, held); end
    end
  endtask

  task automatic test_abort();
    int k, target;
    bit h;
    cam_vsync = 1'b1; step();
    cam_vsync = 1'b0; step();
    n_vec++;
    if (state_o !== 2'd2 || wr_addr !== '0) begin
      n_err++; $display("FAIL abort_start: state=%0d wa=%0d required 2/0", state_o, wr_addr);
    end
    target = $urandom_range(20, N - 20);
    k = 0;
    while (k < target) begin
      h = 1'($urandom_range(0, 1));
      cam_hsync = h;
      step();
      n_vec++;
      if (wr_en !== h || (h && wr_addr !== AW'(k))) begin
        n_err++; $display("FAIL abort_pre_write: we=%0b wa=%0d required %0b/%0d", wr_en, wr_addr, h, k);
      end
      if (h) k++;
    end
    cam_hsync = 1'b0; cam_vsync = 1'b1;
    step();
    n_vec++;
    if (short_frame !== 1'b1 || state_o !== 2'd1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL abort_pulse: sf=%0b state=%0d we=%0b required 1/1/0", short_frame, state_o, wr_en);
    end
    cam_hsync = 1'b1;
    step();
    n_vec++;
    if (short_frame !== 1'b0 || state_o !== 2'd1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL abort_after: sf=%0b state=%0d we=%0b required 0/1/0", short_frame, state_o, wr_en);
    end
    cam_hsync = 1'b0; cam_vsync = 1'b0;
    step();
    n_vec++;
    if (state_o !== 2'd2 || wr_addr !== '0) begin
      n_err++; $display("FAIL abort_restart: state=%0d wa=%0d required 2/0", state_o, wr_addr);
    end
    run_frame(1'b1, 1'b1);
  endtask

  task automatic test_capture_req();
    repeat (3) step();
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
    n_vec++;
    if (state_o !== 2'd1 || frame_valid !== 1'b0) begin
      n_err++; $display("FAIL req_show: state=%0d fv=%0b required 1/0", state_o, frame_valid);
    end
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
    n_vec++;
    if (state_o !== 2'd1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL req_arm_ignored: state=%0d we=%0b required 1/0", state_o, wr_en);
    end
  endtask

  task automatic test_async_reset();
    int t;
    t = $urandom_range(50, N - 50);
    cam_vsync = 1'b0;
    step();
    cam_hsync = 1'b1;
    repeat (t) step();
    n_vec++;
    if (wr_addr !== AW'(t - 1) || state_o !== 2'd2) begin
      n_err++; $display("FAIL rst_pre: wa=%0d state=%0d required %0d/2", wr_addr, state_o, t - 1);
    end
    #3;
    temp_reset = 1'b1;
    #1;
    n_vec++;
    if ({state_o, wr_en, frame_valid, short_frame, wr_addr, rd_addr} !== '0) begin
      n_err++; $display("FAIL rst_async: state=%0d we=%0b wa=%0d ra=%0d required all 0", state_o, wr_en, wr_addr, rd_addr);
    end
    repeat (2) @(posedge PixelClk);
    #1;
    temp_reset = 1'b0;
    n_vec++;
    if (state_o !== 2'd0) begin n_err++; $display("FAIL rst_idle: state=%0d required 0", state_o); end
    step();
    n_vec++;
    if (state_o !== 2'd1) begin n_err++; $display("FAIL rst_arm: state=%0d required 1", state_o); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (state_o !== 2'd1 || wr_en !== 1'b0) begin
        n_err++; $display("FAIL rst_no_stale_edge: state=%0d we=%0b required 1/0", state_o, wr_en);
      end
    end
    cam_hsync = 1'b0; cam_vsync = 1'b1; step();
    cam_vsync = 1'b0; step();
    cam_hsync = 1'b1; step();
    n_vec++;
    if (state_o !== 2'd2 || wr_en !== 1'b1 || wr_addr !== '0) begin
      n_err++; $display("FAIL rst_fresh_capture: state=%0d we=%0b wa=%0d required 2/1/0", state_o, wr_en, wr_addr);
    end
    cam_hsync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_display();
    test_refresh_auto();
    test_abort();
    test_capture_req();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
